// File: rtl/axi_m_arbiter_pkg.sv
// Shared definitions for the two-requester arbiter in front of axi_master:
// bus widths, AXI response codes, arbiter FSM state encodings and the
// completion-event helper.
package axi_m_arbiter_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_STRB_WIDTH = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } arb_state_e;

    // The completion event depends on the command type: a read finishes on
    // read-data-valid and a write on the B handshake. The other event is ignored.
    function automatic logic is_complete(input logic rd0_wr1,
                                         input logic rd_valid,
                                         input logic wr_done);
        logic res;
        if (rd0_wr1) begin
            res = wr_done;
        end else begin
            res = rd_valid;
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_m_arbiter_rr_pick.sv
// Two-input round-robin select. When both inputs request, the requester that
// did not win last time is picked. With a single request that request wins.
// The output is only meaningful while req_i is non-zero.
module axi_m_arbiter_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       grant_o
);

    // Pick the requester index from the request vector and the last winner.
    always_comb begin
        grant_o = 1'b0;
        case (req_i)
            2'b01:   grant_o = 1'b0;
            2'b10:   grant_o = 1'b1;
            2'b11:   grant_o = ~last_i;
            default: grant_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi_m_arbiter.sv
// Two-requester arbiter sharing one axi_master command port between
// instruction fetch (requester 0) and the load/store unit (requester 1).
// One transaction is outstanding at a time. The selected command is latched
// and held on dn_* until completion. The completion is routed back to the
// granted requester combinationally, in the same cycle it arrives.
//
// Build option: define ARB_FIXED_PRIO_EN for fixed priority, in which
// requester 1 always wins a simultaneous request. The default is round-robin.
module axi_m_arbiter
    import axi_m_arbiter_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_WIDTH,
    parameter int DATA_W = AXI_DATA_WIDTH,
    parameter int STRB_W = AXI_STRB_WIDTH
) (
    input  logic              ACLK,
    input  logic              ARESETn,

    input  logic              rq0_access,
    input  logic              rq0_rd0_wr1,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [DATA_W-1:0] rq0_write_data,
    input  logic [STRB_W-1:0] rq0_write_strobe,
    output logic [DATA_W-1:0] rq0_read_data,
    output logic [1:0]        rq0_resp,
    output logic              rq0_done,

    input  logic              rq1_access,
    input  logic              rq1_rd0_wr1,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq1_write_data,
    input  logic [STRB_W-1:0] rq1_write_strobe,
    output logic [DATA_W-1:0] rq1_read_data,
    output logic [1:0]        rq1_resp,
    output logic              rq1_done,

    output logic              dn_access,
    output logic              dn_rd0_wr1,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [DATA_W-1:0] dn_write_data,
    output logic [STRB_W-1:0] dn_write_strobe,
    input  logic [DATA_W-1:0] dn_read_data,
    input  logic              dn_read_data_valid,
    input  logic [1:0]        dn_resp,
    input  logic              dn_write_done,

    output logic              busy
);

    arb_state_e        state_q;
    logic              grant_q;
    logic              busy_q;
    logic              dn_access_q;
    logic              dn_rd0_wr1_q;
    logic [ADDR_W-1:0] dn_addr_q;
    logic [DATA_W-1:0] dn_write_data_q;
    logic [STRB_W-1:0] dn_write_strobe_q;

    logic [1:0]        req_s;
    logic              pick_s;
    logic              done_s;

    assign req_s = {rq1_access, rq0_access};

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: the load/store unit wins whenever it requests.
    always_comb begin
        pick_s = 1'b0;
        if (rq1_access) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end
`else
    logic rr_last_q;

    axi_m_arbiter_rr_pick u_rr_pick (
        .req_i   (req_s),
        .last_i  (rr_last_q),
        .grant_o (pick_s)
    );

    // Remember the last completed winner. It resets to 1 so requester 0 wins first.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rr_last_q <= 1'b1;
        end else if (done_s) begin
            rr_last_q <= grant_q;
        end else begin
            rr_last_q <= rr_last_q;
        end
    end
`endif

    // Completion of the granted command. Events are only accepted in WAIT.
    always_comb begin
        done_s = 1'b0;
        if (state_q == ST_WAIT) begin
            done_s = is_complete(dn_rd0_wr1_q, dn_read_data_valid, dn_write_done);
        end else begin
            done_s = 1'b0;
        end
    end

    // Arbiter FSM: arbitrate in IDLE, pulse dn_access in ISSUE, hold fields in WAIT.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q           <= ST_IDLE;
            grant_q           <= 1'b0;
            busy_q            <= 1'b0;
            dn_access_q       <= 1'b0;
            dn_rd0_wr1_q      <= 1'b0;
            dn_addr_q         <= {ADDR_W{1'b0}};
            dn_write_data_q   <= {DATA_W{1'b0}};
            dn_write_strobe_q <= {STRB_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_s != 2'b00) begin
                        grant_q     <= pick_s;
                        dn_access_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ISSUE;
                        if (pick_s) begin
                            dn_rd0_wr1_q      <= rq1_rd0_wr1;
                            dn_addr_q         <= rq1_addr;
                            dn_write_data_q   <= rq1_write_data;
                            dn_write_strobe_q <= rq1_write_strobe;
                        end else begin
                            dn_rd0_wr1_q      <= rq0_rd0_wr1;
                            dn_addr_q         <= rq0_addr;
                            dn_write_data_q   <= rq0_write_data;
                            dn_write_strobe_q <= rq0_write_strobe;
                        end
                    end else begin
                        dn_access_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // One-cycle pulse so axi_master does not re-trigger on return to its IDLE.
                    dn_access_q <= 1'b0;
                    busy_q      <= 1'b1;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    dn_access_q <= 1'b0;
                    if (done_s) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT;
                    end
                end
                default: begin
                    dn_access_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // Route the completion to the granted requester only; the other side stays 0.
    always_comb begin
        rq0_done      = 1'b0;
        rq0_resp      = 2'b00;
        rq0_read_data = {DATA_W{1'b0}};
        rq1_done      = 1'b0;
        rq1_resp      = 2'b00;
        rq1_read_data = {DATA_W{1'b0}};
        if (done_s) begin
            if (grant_q) begin
                rq1_done = 1'b1;
                rq1_resp = dn_resp;
                if (dn_rd0_wr1_q) begin
                    rq1_read_data = {DATA_W{1'b0}};
                end else begin
                    rq1_read_data = dn_read_data;
                end
            end else begin
                rq0_done = 1'b1;
                rq0_resp = dn_resp;
                if (dn_rd0_wr1_q) begin
                    rq0_read_data = {DATA_W{1'b0}};
                end else begin
                    rq0_read_data = dn_read_data;
                end
            end
        end else begin
            rq0_done = 1'b0;
            rq1_done = 1'b0;
        end
    end

    assign dn_access       = dn_access_q;
    assign dn_rd0_wr1      = dn_rd0_wr1_q;
    assign dn_addr         = dn_addr_q;
    assign dn_write_data   = dn_write_data_q;
    assign dn_write_strobe = dn_write_strobe_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_axi_m_arbiter.sv
// Directed bench for axi_m_arbiter. Inputs are driven 1 ns after the rising
// edge and outputs are sampled on the falling edge. Define ARB_FIXED_PRIO_EN
// consistently for the bench and the RTL.
module tb_axi_m_arbiter;

    logic        ACLK;
    logic        ARESETn;
    logic        rq0_access, rq0_rd0_wr1, rq0_done;
    logic [31:0] rq0_addr, rq0_write_data, rq0_read_data;
    logic [3:0]  rq0_write_strobe;
    logic [1:0]  rq0_resp;
    logic        rq1_access, rq1_rd0_wr1, rq1_done;
    logic [31:0] rq1_addr, rq1_write_data, rq1_read_data;
    logic [3:0]  rq1_write_strobe;
    logic [1:0]  rq1_resp;
    logic        dn_access, dn_rd0_wr1, dn_read_data_valid, dn_write_done;
    logic [31:0] dn_addr, dn_write_data, dn_read_data;
    logic [3:0]  dn_write_strobe;
    logic [1:0]  dn_resp;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    axi_m_arbiter dut (
        .ACLK               (ACLK),
        .ARESETn            (ARESETn),
        .rq0_access         (rq0_access),
        .rq0_rd0_wr1        (rq0_rd0_wr1),
        .rq0_addr           (rq0_addr),
        .rq0_write_data     (rq0_write_data),
        .rq0_write_strobe   (rq0_write_strobe),
        .rq0_read_data      (rq0_read_data),
        .rq0_resp           (rq0_resp),
        .rq0_done           (rq0_done),
        .rq1_access         (rq1_access),
        .rq1_rd0_wr1        (rq1_rd0_wr1),
        .rq1_addr           (rq1_addr),
        .rq1_write_data     (rq1_write_data),
        .rq1_write_strobe   (rq1_write_strobe),
        .rq1_read_data      (rq1_read_data),
        .rq1_resp           (rq1_resp),
        .rq1_done           (rq1_done),
        .dn_access          (dn_access),
        .dn_rd0_wr1         (dn_rd0_wr1),
        .dn_addr            (dn_addr),
        .dn_write_data      (dn_write_data),
        .dn_write_strobe    (dn_write_strobe),
        .dn_read_data       (dn_read_data),
        .dn_read_data_valid (dn_read_data_valid),
        .dn_resp            (dn_resp),
        .dn_write_done      (dn_write_done),
        .busy               (busy)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge ACLK);
        #1;
    endtask

    // Wait (bounded) for the dn_access pulse, sampled on falling edges.
    task automatic wait_access(input string tag);
        int n;
        n = 0;
        @(negedge ACLK);
        while (dn_access !== 1'b1 && n < 10) begin
            @(negedge ACLK);
            n++;
        end
        check_val(tag, {31'd0, dn_access}, 32'd1);
    endtask

    function automatic logic exp_grant(input int r);
`ifdef ARB_FIXED_PRIO_EN
        return 1'b1;
`else
        return (r % 2 == 1) ? 1'b1 : 1'b0;
`endif
    endfunction

    initial begin
        logic g;
        ARESETn = 1'b0;
        rq0_access = 1'b0; rq0_rd0_wr1 = 1'b0; rq0_addr = 32'd0; rq0_write_data = 32'd0; rq0_write_strobe = 4'd0;
        rq1_access = 1'b0; rq1_rd0_wr1 = 1'b0; rq1_addr = 32'd0; rq1_write_data = 32'd0; rq1_write_strobe = 4'd0;
        dn_read_data = 32'd0; dn_read_data_valid = 1'b0; dn_resp = 2'b00; dn_write_done = 1'b0;
        repeat (3) @(posedge ACLK);
        #1 ARESETn = 1'b1;

        // Reset state
        @(negedge ACLK);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_dn_access", {31'd0, dn_access}, 32'd0);
        check_val("rst_dn_addr", dn_addr, 32'd0);
        check_val("rst_rq0_done", {31'd0, rq0_done}, 32'd0);
        check_val("rst_rq1_done", {31'd0, rq1_done}, 32'd0);

        // Single read from requester 0, data 4 cycles after dn_access
        nxt();
        rq0_access = 1'b1; rq0_rd0_wr1 = 1'b0; rq0_addr = 32'h100;
        @(negedge ACLK);
        check_val("rd_arb_cycle_access", {31'd0, dn_access}, 32'd0);
        @(negedge ACLK);
        check_val("rd_issue_access", {31'd0, dn_access}, 32'd1);
        check_val("rd_issue_addr", dn_addr, 32'h100);
        check_val("rd_issue_cmd", {31'd0, dn_rd0_wr1}, 32'd0);
        check_val("rd_issue_busy", {31'd0, busy}, 32'd1);
        nxt();
        @(negedge ACLK);
        check_val("rd_wait_access_pulse", {31'd0, dn_access}, 32'd0);
        check_val("rd_wait_addr_held", dn_addr, 32'h100);
        nxt(); nxt(); nxt();
        dn_read_data_valid = 1'b1; dn_read_data = 32'hDEADBEEF; dn_resp = 2'b00;
        @(negedge ACLK);
        check_val("rd_rq0_done", {31'd0, rq0_done}, 32'd1);
        check_val("rd_rq0_data", rq0_read_data, 32'hDEADBEEF);
        check_val("rd_rq0_resp", {30'd0, rq0_resp}, 32'd0);
        check_val("rd_rq1_done", {31'd0, rq1_done}, 32'd0);
        check_val("rd_rq1_data", rq1_read_data, 32'd0);
        nxt();
        dn_read_data_valid = 1'b0; rq0_access = 1'b0;
        @(negedge ACLK);
        check_val("rd_after_done", {31'd0, rq0_done}, 32'd0);
        check_val("rd_after_busy", {31'd0, busy}, 32'd0);

        // Single write from requester 1, with a wrong-type event in WAIT
        nxt();
        rq1_access = 1'b1; rq1_rd0_wr1 = 1'b1; rq1_addr = 32'h200;
        rq1_write_data = 32'h12345678; rq1_write_strobe = 4'b0011;
        @(negedge ACLK);
        @(negedge ACLK);
        check_val("wr_issue_access", {31'd0, dn_access}, 32'd1);
        check_val("wr_issue_cmd", {31'd0, dn_rd0_wr1}, 32'd1);
        check_val("wr_issue_addr", dn_addr, 32'h200);
        check_val("wr_issue_data", dn_write_data, 32'h12345678);
        check_val("wr_issue_strb", {28'd0, dn_write_strobe}, 32'h3);
        nxt(); nxt();
        dn_read_data_valid = 1'b1; dn_read_data = 32'hAAAA5555;
        @(negedge ACLK);
        check_val("wr_wrong_type_ignored", {31'd0, rq1_done}, 32'd0);
        check_val("wr_wait_data_held", dn_write_data, 32'h12345678);
        check_val("wr_wait_strb_held", {28'd0, dn_write_strobe}, 32'h3);
        nxt();
        dn_read_data_valid = 1'b0; dn_write_done = 1'b1; dn_resp = 2'b00; dn_read_data = 32'h00000055;
        @(negedge ACLK);
        check_val("wr_rq1_done", {31'd0, rq1_done}, 32'd1);
        check_val("wr_rq1_resp", {30'd0, rq1_resp}, 32'd0);
        check_val("wr_rq1_data_zero", rq1_read_data, 32'd0);
        check_val("wr_rq0_done", {31'd0, rq0_done}, 32'd0);
        nxt();
        dn_write_done = 1'b0; rq1_access = 1'b0;

        // Simultaneous requests, four rounds
        for (int r = 0; r < 4; r++) begin
            nxt();
            rq0_access = 1'b1; rq0_rd0_wr1 = 1'b0; rq0_addr = 32'h300;
            rq1_access = 1'b1; rq1_rd0_wr1 = 1'b0; rq1_addr = 32'h400;
            g = exp_grant(r);
            wait_access($sformatf("sim%0d_access", r));
            check_val($sformatf("sim%0d_grant_addr", r), dn_addr, g ? 32'h400 : 32'h300);
            nxt(); nxt();
            dn_read_data_valid = 1'b1; dn_read_data = 32'hA0 + r; dn_resp = 2'b00;
            @(negedge ACLK);
            check_val($sformatf("sim%0d_rq0_done", r), {31'd0, rq0_done}, {31'd0, ~g});
            check_val($sformatf("sim%0d_rq1_done", r), {31'd0, rq1_done}, {31'd0, g});
            check_val($sformatf("sim%0d_data", r), g ? rq1_read_data : rq0_read_data, 32'hA0 + r);
            nxt();
            dn_read_data_valid = 1'b0; rq0_access = 1'b0; rq1_access = 1'b0;
        end

        // Request during WAIT, with error response on the in-flight read
        nxt();
        rq0_access = 1'b1; rq0_rd0_wr1 = 1'b0; rq0_addr = 32'h500;
        wait_access("wq_rq0_access");
        check_val("wq_rq0_addr", dn_addr, 32'h500);
        nxt();
        rq1_access = 1'b1; rq1_rd0_wr1 = 1'b1; rq1_addr = 32'h600;
        rq1_write_data = 32'h0BADF00D; rq1_write_strobe = 4'hF;
        nxt();
        dn_read_data_valid = 1'b1; dn_read_data = 32'h11112222; dn_resp = 2'b10;
        @(negedge ACLK);
        check_val("err_rq0_done", {31'd0, rq0_done}, 32'd1);
        check_val("err_rq0_resp", {30'd0, rq0_resp}, 32'h2);
        check_val("wq_rq1_not_done", {31'd0, rq1_done}, 32'd0);
        check_val("wq_addr_still_rq0", dn_addr, 32'h500);
        nxt();
        dn_read_data_valid = 1'b0; dn_resp = 2'b00; rq0_access = 1'b0;
        @(negedge ACLK);
        check_val("wq_gap_idle", {31'd0, dn_access}, 32'd0);
        @(negedge ACLK);
        check_val("wq_rq1_access_2cyc", {31'd0, dn_access}, 32'd1);
        check_val("wq_rq1_addr", dn_addr, 32'h600);
        nxt(); nxt();
        dn_write_done = 1'b1;
        @(negedge ACLK);
        check_val("wq_rq1_done", {31'd0, rq1_done}, 32'd1);
        nxt();
        dn_write_done = 1'b0; rq1_access = 1'b0;

        // Completion events in IDLE are ignored
        nxt();
        dn_read_data_valid = 1'b1; dn_write_done = 1'b1;
        @(negedge ACLK);
        check_val("idle_stray_rq0", {31'd0, rq0_done}, 32'd0);
        check_val("idle_stray_rq1", {31'd0, rq1_done}, 32'd0);
        nxt();
        dn_read_data_valid = 1'b0; dn_write_done = 1'b0;

        // Asynchronous reset during WAIT
        nxt();
        rq0_access = 1'b1; rq0_rd0_wr1 = 1'b1; rq0_addr = 32'h700;
        rq0_write_data = 32'hCAFEF00D; rq0_write_strobe = 4'hF;
        wait_access("rst_mid_access");
        nxt();
        dn_read_data_valid = 1'b1; dn_write_done = 1'b0;
        #1 ARESETn = 1'b0;
        dn_write_done = 1'b1;
        #1;
        check_val("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_val("rst_mid_dn_addr", dn_addr, 32'd0);
        check_val("rst_mid_dn_wdata", dn_write_data, 32'd0);
        check_val("rst_mid_dn_cmd", {31'd0, dn_rd0_wr1}, 32'd0);
        check_val("rst_mid_rq0_done", {31'd0, rq0_done}, 32'd0);
        rq0_access = 1'b0; dn_read_data_valid = 1'b0; dn_write_done = 1'b0;
        nxt();
        ARESETn = 1'b1;
        nxt();
        dn_read_data_valid = 1'b1; dn_read_data = 32'h77777777;
        @(negedge ACLK);
        check_val("post_rst_stray_rq0", {31'd0, rq0_done}, 32'd0);
        check_val("post_rst_stray_rq1", {31'd0, rq1_done}, 32'd0);
        nxt();
        dn_read_data_valid = 1'b0;

        // First simultaneous request after reset
        nxt();
        rq0_access = 1'b1; rq0_rd0_wr1 = 1'b0; rq0_addr = 32'h800;
        rq1_access = 1'b1; rq1_rd0_wr1 = 1'b0; rq1_addr = 32'h900;
        g = exp_grant(0);
        wait_access("post_rst_access");
        check_val("post_rst_grant_addr", dn_addr, g ? 32'h900 : 32'h800);
        nxt(); nxt();
        dn_read_data_valid = 1'b1; dn_read_data = 32'h5A5A5A5A;
        @(negedge ACLK);
        check_val("post_rst_done", {31'd0, g ? rq1_done : rq0_done}, 32'd1);
        check_val("post_rst_data", g ? rq1_read_data : rq0_read_data, 32'h5A5A5A5A);
        nxt();
        dn_read_data_valid = 1'b0; rq0_access = 1'b0; rq1_access = 1'b0;
        repeat (2) nxt();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_m_arbiter.md
Name: axi_m_arbiter

Overview:
- Two-requester arbiter that shares one axi_master CPU-side port (M_* interface) between requester 0 (instruction fetch) and requester 1 (load/store unit).
- Serialises transactions with one outstanding transaction in total.
- Selects by round-robin, holds the selected requester's command stable until completion, and routes the read data or write completion back to the granted requester only.
- Sits between the core's bus ports and axi_master, in the ACLK domain.

Parameters:
- ADDR_W, `AXI_ADDR_WIDTH (32), address width.
- DATA_W, `AXI_DATA_WIDTH (32), data width.
- STRB_W, `AXI_STRB_WIDTH (4), write strobe width.

Ports:
- ACLK  in  1  clock; one clock for the whole block.
- ARESETn  in  1  reset; asynchronous, active-low.
- rqN_access (N=0,1)  in  1  request; held high with stable fields until rqN_done.
- rqN_rd0_wr1  in  1  command: 0 = read, 1 = write.
- rqN_addr  in  ADDR_W  address.
- rqN_write_data  in  DATA_W  write data.
- rqN_write_strobe  in  STRB_W  byte strobes.
- rqN_read_data  out  DATA_W  read data; valid only with rqN_done on a read.
- rqN_resp  out  2  AXI response code, valid with rqN_done.
- rqN_done  out  1  one-cycle completion pulse.
- dn_access  out  1  to axi_master M_access.
- dn_rd0_wr1  out  1  to M_rd0_wr1.
- dn_addr  out  ADDR_W  to M_addr.
- dn_write_data  out  DATA_W  to M_write_data.
- dn_write_strobe  out  STRB_W  to M_write_strobe.
- dn_read_data  in  DATA_W  from M_read_data.
- dn_read_data_valid  in  1  from M_read_data_valid.
- dn_resp  in  2  from M_resp (read) / BRESP (write).
- dn_write_done  in  1  pulse when the B handshake completes (BVALID & BREADY).
- busy  out  1  a transaction is in flight.

Behaviour:
- Reset values: state IDLE, busy 0, grant 0, rr_last 1 (so requester 0 wins first), dn_* 0, rqN_done 0, rqN_read_data 0, rqN_resp 0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - No request: stay in IDLE.
  - Any rqN_access high: register grant (single request wins; both high picks the requester != rr_last), latch its rd0_wr1/addr/write_data/write_strobe into the dn_* registers, go to ISSUE.
- ISSUE:
  - dn_access = 1 for exactly one cycle (axi_master samples it in its IDLE state); go to WAIT.
  - dn_access is a pulse so axi_master does not re-trigger when it returns to IDLE.
- WAIT:
  - dn_access = 0; dn_* fields stay at the latched values throughout, because axi_master samples address and data after the access cycle.
  - Completion event: read = dn_read_data_valid; write = dn_write_done.
  - On completion:
    - rq[grant]_done = 1 in the same cycle (combinational pass-through, zero added latency).
    - rq[grant]_read_data = dn_read_data on reads, 0 on writes.
    - rq[grant]_resp = dn_resp.
    - rr_last <= grant; go to IDLE.
- busy = 1 in ISSUE and WAIT.
- Request-to-dn_access latency: 2 cycles (IDLE arbitrate, then ISSUE).
- The non-granted requester's outputs stay 0.
- Back-to-back: after completion, one IDLE cycle is guaranteed before the next grant.
- The requester must deassert access the cycle after done; if access is still high in IDLE, it is treated as a new request.
- Completion of the wrong type in WAIT (e.g. dn_write_done while a read is granted) is ignored.
- Any dn completion in IDLE or ISSUE is ignored.
- A requester dropping access before done: the transaction still completes downstream; the done pulse is still issued.
- Asynchronous reset mid-transaction: immediate return to IDLE with all outputs at reset values. axi_master shares ARESETn, so both blocks restart together.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 1 (data) always wins a simultaneous request; rr_last is not implemented.
- Undefined (default): round-robin as described above.

Decomposition:
- Shared package axi_defines.vh: AXI_ADDR_WIDTH, AXI_DATA_WIDTH, AXI_STRB_WIDTH, and the response codes RESP_OKAY=2'b00 / RESP_SLVERR=2'b10 (new defines).
- Arbiter FSM state encodings are localparams.
- Optional sub-module axi_rr_pick (2-input round-robin select: req[1:0], last -> grant). Everything else stays in a single module.

Test Plan:
- Single read: rq0 read addr 0x100; dn_read_data_valid 4 cycles after dn_access with data 0xDEADBEEF, resp 0 -> rq0_done pulse, rq0_read_data=0xDEADBEEF; rq1 outputs stay 0.
- Single write: rq1 write addr 0x200, data 0x12345678, strb 4'b0011 -> dn_* show those values from ISSUE until dn_write_done; rq1_done with rq1_resp=0, rq1_read_data=0.
- Simultaneous requests, repeated 4 times with both held and re-asserted -> grant order 0,1,0,1. With ARB_FIXED_PRIO_EN defined -> order 1,1,1,1.
- Request during WAIT: rq1 asserted while rq0 is in flight -> rq1 waits; its dn_access comes exactly 2 cycles after rq0_done.
- Error response: dn_resp=2'b10 on a read -> rq0_resp=2'b10 with rq0_done.
- Reset mid-transaction: ARESETn low during WAIT -> all outputs 0 the same cycle. After release, a stray dn_read_data_valid produces no done. The next request issues normally.
